// File: rtl/load_mem_ctrl_pkg.sv
// load_mem_ctrl_pkg: shared memory-access control codes, size encodings and load helpers
// Holds the SB/SH/SW store codes next to the LB/LBU/LH/LHU/LW load codes,
// the data_size encodings, and small decode helpers used by the load path.
package load_mem_ctrl_pkg;

    localparam logic [5:0] SB_CONTROL  = 6'h01;
    localparam logic [5:0] SH_CONTROL  = 6'h02;
    localparam logic [5:0] SW_CONTROL  = 6'h03;
    localparam logic [5:0] LB_CONTROL  = 6'h04;
    localparam logic [5:0] LBU_CONTROL = 6'h05;
    localparam logic [5:0] LH_CONTROL  = 6'h06;
    localparam logic [5:0] LHU_CONTROL = 6'h07;
    localparam logic [5:0] LW_CONTROL  = 6'h08;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic isLoadCtrl(input logic [5:0] ctrl);
        return ctrl == LB_CONTROL || ctrl == LBU_CONTROL || ctrl == LH_CONTROL ||
               ctrl == LHU_CONTROL || ctrl == LW_CONTROL;
    endfunction

    function automatic logic [1:0] ctrlSize(input logic [5:0] ctrl);
        return (ctrl == LW_CONTROL) ? SIZE_WORD :
               (ctrl == LH_CONTROL || ctrl == LHU_CONTROL) ? SIZE_HALF : SIZE_BYTE;
    endfunction

    function automatic logic misaligned(input logic [5:0] ctrl, input logic [1:0] off);
        return (ctrl == LW_CONTROL) ? (off != 2'b00) :
               (ctrl == LH_CONTROL || ctrl == LHU_CONTROL) ? off[0] : 1'b0;
    endfunction

endpackage

// File: rtl/load_mem_ctrl_extract.sv
// load_extract: selects the addressed byte/halfword lane of a read word and extends it
// Ports: ctrl (load code), offset (byte offset addr[1:0]), rdata (read word),
//        result (sign/zero-extended load value). Lane 0 is the most significant byte.
module load_extract
    import load_mem_ctrl_pkg::*;
(
    input  logic [5:0]  ctrl,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    always_comb begin
        laneByte = offset[1] ? (offset[0] ? rdata[7:0] : rdata[15:8])
                             : (offset[0] ? rdata[23:16] : rdata[31:24]);
        laneHalf = offset[1] ? rdata[15:0] : rdata[31:16];
        result   = (ctrl == LB_CONTROL)  ? {{24{laneByte[7]}}, laneByte} :
                   (ctrl == LBU_CONTROL) ? {24'd0, laneByte} :
                   (ctrl == LH_CONTROL)  ? {{16{laneHalf[15]}}, laneHalf} :
                   (ctrl == LHU_CONTROL) ? {16'd0, laneHalf} : rdata;
    end

endmodule

// File: rtl/load_mem_ctrl.sv
// load_mem_ctrl: M-stage load controller over an sram-like req/addr_ok/data_ok read port
// Ports: clk/resetn (sync active-low); ld_valid/ld_ctrl/ld_addr load request from M;
//        flush kills the in-flight load; data_* is the memory read handshake;
//        ld_result/ld_done registered W-stage result; ld_stall freezes IF..M;
//        adel/badvaddr report a misaligned load address.
module load_mem_ctrl
    import load_mem_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          ld_valid,
    input  logic [5:0]    ld_ctrl,
    input  logic [AW-1:0] ld_addr,
    input  logic          flush,
    output logic          data_req,
    output logic [AW-1:0] data_addr,
    output logic [1:0]    data_size,
    input  logic          data_addr_ok,
    input  logic          data_data_ok,
    input  logic [DW-1:0] data_rdata,
    output logic [31:0]   ld_result,
    output logic          ld_done,
    output logic          ld_stall,
    output logic          adel,
    output logic [AW-1:0] badvaddr
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} stateT;

    stateT         stateQ, stateD;
    logic [5:0]    ctrlQ;
    logic [AW-1:0] addrQ;
    logic [1:0]    sizeQ;
    logic [31:0]   extracted;
    logic          isLoad, start, misStart;

    load_extract uExtract (
        .ctrl   (ctrlQ),
        .offset (addrQ[1:0]),
        .rdata  (data_rdata),
        .result (extracted)
    );

    assign isLoad    = ld_valid && isLoadCtrl(ld_ctrl);
    // ld_done blocks a restart so the still-asserted ld_valid of the retiring load is ignored
    assign start     = isLoad && !flush && !ld_done;
    assign misStart  = misaligned(ld_ctrl, ld_addr[1:0]);
    assign data_req  = stateQ == ADDR;
    assign data_addr = addrQ;
    assign data_size = sizeQ;

    always_comb begin
        stateD   = stateQ;
        ld_stall = 1'b0;
        case (stateQ)
            IDLE: begin
                ld_stall = start && !misStart;
                stateD   = (start && !misStart) ? ADDR : IDLE;
            end
            ADDR: begin
                ld_stall = 1'b1;
                stateD   = flush ? (data_addr_ok ? DRAIN : IDLE) : (data_addr_ok ? DATA : ADDR);
            end
            DATA: begin
                ld_stall = 1'b1;
                stateD   = data_data_ok ? IDLE : (flush ? DRAIN : DATA);
            end
            default: begin
                ld_stall = isLoad;
                stateD   = data_data_ok ? IDLE : DRAIN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stateQ    <= IDLE;
            ctrlQ     <= '0;
            addrQ     <= '0;
            sizeQ     <= '0;
            ld_result <= '0;
            ld_done   <= 1'b0;
            adel      <= 1'b0;
            badvaddr  <= '0;
        end else begin
            stateQ  <= stateD;
            ld_done <= 1'b0;
            adel    <= 1'b0;
            if (stateQ == IDLE && start && misStart) begin
                adel     <= 1'b1;
                badvaddr <= ld_addr;
            end
            if (stateQ == IDLE && start && !misStart) begin
                ctrlQ <= ld_ctrl;
                addrQ <= ld_addr;
                sizeQ <= ctrlSize(ld_ctrl);
            end
            if (stateQ == DATA && data_data_ok && !flush) begin
                ld_result <= extracted;
                ld_done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_mem_ctrl.sv
// tb_load_mem_ctrl: directed self-checking bench for load_mem_ctrl
module tb_load_mem_ctrl;
    import load_mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ld_valid;
    logic [5:0]  ld_ctrl;
    logic [31:0] ld_addr;
    logic        flush;
    logic        data_req;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] ld_result;
    logic        ld_done;
    logic        ld_stall;
    logic        adel;
    logic [31:0] badvaddr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_mem_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .ld_valid     (ld_valid),
        .ld_ctrl      (ld_ctrl),
        .ld_addr      (ld_addr),
        .flush        (flush),
        .data_req     (data_req),
        .data_addr    (data_addr),
        .data_size    (data_size),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .ld_result    (ld_result),
        .ld_done      (ld_done),
        .ld_stall     (ld_stall),
        .adel         (adel),
        .badvaddr     (badvaddr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full load with addr_ok in the request cycle and data_ok one cycle later
    task automatic doLoad(input string tag, input logic [5:0] c, input logic [31:0] a,
                          input logic [31:0] rd, input logic [1:0] sz, input logic [31:0] exp);
        ld_valid = 1; ld_ctrl = c; ld_addr = a;
        #0;
        chk({tag, " stall T"}, 32'(ld_stall), 1);
        chk({tag, " req T"}, 32'(data_req), 0);
        step();
        data_addr_ok = 1;
        chk({tag, " req T+1"}, 32'(data_req), 1);
        chk({tag, " addr T+1"}, data_addr, a);
        chk({tag, " size T+1"}, 32'(data_size), 32'(sz));
        chk({tag, " stall T+1"}, 32'(ld_stall), 1);
        chk({tag, " adel T+1"}, 32'(adel), 0);
        step();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = rd;
        chk({tag, " req T+2"}, 32'(data_req), 0);
        chk({tag, " stall T+2"}, 32'(ld_stall), 1);
        chk({tag, " done T+2"}, 32'(ld_done), 0);
        step();
        data_data_ok = 0; data_rdata = 32'hCAFE_F00D;
        chk({tag, " done T+3"}, 32'(ld_done), 1);
        chk({tag, " result"}, ld_result, exp);
        chk({tag, " stall T+3"}, 32'(ld_stall), 0);
        ld_valid = 0;
        step();
        chk({tag, " done T+4"}, 32'(ld_done), 0);
        chk({tag, " result held"}, ld_result, exp);
    endtask

    initial begin
        resetn = 0; ld_valid = 0; ld_ctrl = 0; ld_addr = 0; flush = 0;
        data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        step();
        step();
        resetn = 1;
        chk("rst req", 32'(data_req), 0);
        chk("rst addr", data_addr, 0);
        chk("rst size", 32'(data_size), 0);
        chk("rst result", ld_result, 0);
        chk("rst done", 32'(ld_done), 0);
        chk("rst adel", 32'(adel), 0);
        chk("rst badvaddr", badvaddr, 0);
        chk("rst stall", 32'(ld_stall), 0);

        doLoad("lb100", LB_CONTROL, 32'h100, 32'h80FF_1234, SIZE_BYTE, 32'hFFFF_FF80);
        doLoad("lhu102", LHU_CONTROL, 32'h102, 32'h1234_ABCD, SIZE_HALF, 32'h0000_ABCD);
        doLoad("lh102", LH_CONTROL, 32'h102, 32'h1234_ABCD, SIZE_HALF, 32'hFFFF_ABCD);
        doLoad("lbu103", LBU_CONTROL, 32'h103, 32'h1234_ABCD, SIZE_BYTE, 32'h0000_00CD);
        doLoad("lb103", LB_CONTROL, 32'h103, 32'h1234_ABCD, SIZE_BYTE, 32'hFFFF_FFCD);
        doLoad("lh100", LH_CONTROL, 32'h100, 32'h8001_0000, SIZE_HALF, 32'hFFFF_8001);
        doLoad("lw104", LW_CONTROL, 32'h104, 32'hA5A5_5A5A, SIZE_WORD, 32'hA5A5_5A5A);

        ld_valid = 1; ld_ctrl = LW_CONTROL; ld_addr = 32'h101;
        #0;
        chk("lw101 stall", 32'(ld_stall), 0);
        step();
        ld_valid = 0;
        chk("lw101 adel", 32'(adel), 1);
        chk("lw101 badvaddr", badvaddr, 32'h101);
        chk("lw101 req", 32'(data_req), 0);
        step();
        chk("lw101 adel pulse", 32'(adel), 0);
        chk("lw101 req after", 32'(data_req), 0);

        ld_valid = 1; ld_ctrl = LH_CONTROL; ld_addr = 32'h103;
        step();
        ld_valid = 0;
        chk("lh103 adel", 32'(adel), 1);
        chk("lh103 badvaddr", badvaddr, 32'h103);
        chk("lh103 req", 32'(data_req), 0);
        step();

        ld_valid = 1; ld_ctrl = LW_CONTROL; ld_addr = 32'h200;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("lw200 wait req", 32'(data_req), 1);
            chk("lw200 wait addr", data_addr, 32'h200);
            chk("lw200 wait size", 32'(data_size), 2);
            step();
        end
        data_addr_ok = 1;
        chk("lw200 req4", 32'(data_req), 1);
        step();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0BAD_BEEF;
        step();
        data_data_ok = 0;
        chk("lw200 done", 32'(ld_done), 1);
        chk("lw200 result", ld_result, 32'h0BAD_BEEF);
        ld_valid = 0;
        step();

        ld_valid = 1; ld_ctrl = LW_CONTROL; ld_addr = 32'h208;
        step();
        chk("fladdr req1", 32'(data_req), 1);
        step();
        flush = 1;
        chk("fladdr req2", 32'(data_req), 1);
        step();
        flush = 0; ld_valid = 0;
        chk("fladdr withdrawn", 32'(data_req), 0);
        chk("fladdr stall", 32'(ld_stall), 0);
        step();
        chk("fladdr no done", 32'(ld_done), 0);
        chk("fladdr idle req", 32'(data_req), 0);

        ld_valid = 1; ld_ctrl = LW_CONTROL; ld_addr = 32'h300;
        step();
        data_addr_ok = 1;
        step();
        data_addr_ok = 0; flush = 1; ld_addr = 32'h304;
        chk("drain data stall", 32'(ld_stall), 1);
        step();
        flush = 0;
        chk("drain stall", 32'(ld_stall), 1);
        chk("drain req", 32'(data_req), 0);
        chk("drain done", 32'(ld_done), 0);
        step();
        data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
        chk("drain req2", 32'(data_req), 0);
        step();
        data_data_ok = 0;
        chk("drain discard done", 32'(ld_done), 0);
        chk("drain discard result", ld_result, 32'h0BAD_BEEF);
        chk("drain restart stall", 32'(ld_stall), 1);
        chk("drain restart req", 32'(data_req), 0);
        step();
        data_addr_ok = 1;
        chk("second req", 32'(data_req), 1);
        chk("second addr", data_addr, 32'h304);
        step();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1122_3344;
        step();
        data_data_ok = 0; ld_valid = 0;
        chk("second done", 32'(ld_done), 1);
        chk("second result", ld_result, 32'h1122_3344);
        step();

        ld_valid = 1; ld_ctrl = LB_CONTROL; ld_addr = 32'h10F;
        step();
        data_addr_ok = 1;
        step();
        data_addr_ok = 0; ld_valid = 0; resetn = 0;
        step();
        resetn = 1;
        chk("rstdata req", 32'(data_req), 0);
        chk("rstdata addr", data_addr, 0);
        chk("rstdata size", 32'(data_size), 0);
        chk("rstdata result", ld_result, 0);
        chk("rstdata badvaddr", badvaddr, 0);
        chk("rstdata done", 32'(ld_done), 0);
        chk("rstdata stall", 32'(ld_stall), 0);
        step();
        chk("rstdata idle req", 32'(data_req), 0);

        ld_valid = 1; ld_ctrl = SW_CONTROL; ld_addr = 32'h400;
        #0;
        chk("nonload stall", 32'(ld_stall), 0);
        step();
        chk("nonload req", 32'(data_req), 0);
        chk("nonload adel", 32'(adel), 0);
        step();
        chk("nonload req2", 32'(data_req), 0);
        ld_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
